req_onehot_arbiter: RTL and testbench

- Upstream feeder for the 8-to-3 encoder in the request path.
- Captures up to 8 asynchronous-to-protocol request lines into sticky pending bits and selects the highest-priority pending request.
- Presents that request as a strictly one-hot 8-bit word with a valid/ready handshake, so the downstream encoder only ever sees a single active bit or all-zeros.
- Clears each pending bit when the consumer accepts it.

---
 rtl/req_onehot_arbiter.sv | 102 ++++++++++
 tb/tb_req_onehot_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/req_onehot_arbiter.sv
// Sticky request capture with fixed-priority one-hot grant and valid/ready handshake.
// Feeds the 8-to-3 encoder: onehot_out is either all-zero or carries exactly one set bit.
module req_onehot_arbiter #(
  parameter int unsigned N         = 8,
  parameter bit          EDGE_MODE = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_in,
  input  logic         clr_all,
  input  logic         ready_in,
  output logic [N-1:0] onehot_out,
  output logic         valid_out,
  output logic [N-1:0] pending,
  output logic         overflow
);

  typedef enum logic {IDLE, PRESENT} state_e;

  state_e       state_q;
  logic [N-1:0] req_prev_q;

  logic [N-1:0] rise;
  logic         acc;
  logic [N-1:0] clr_mask;
  logic [N-1:0] pending_d;
  logic         overflow_d;
  logic [N-1:0] rem;

  // One-hot of the highest set bit; later iterations overwrite, so MSB wins.
  function automatic logic [N-1:0] sel_high(input logic [N-1:0] v);
    logic [N-1:0] s;
    s = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (v[i]) begin
        s    = '0;
        s[i] = 1'b1;
      end
    end
    return s;
  endfunction

  always_comb begin
    rise       = EDGE_MODE ? (req_in & ~req_prev_q) : req_in;
    acc        = valid_out & ready_in;
    clr_mask   = acc ? onehot_out : '0;
    pending_d  = (pending & ~clr_mask) | rise;
    overflow_d = EDGE_MODE && (|(rise & pending & ~clr_mask));
    rem        = pending & ~onehot_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_prev_q <= '0;
      pending    <= '0;
      onehot_out <= '0;
      valid_out  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      req_prev_q <= req_in;
      if (clr_all) begin
        // Flush drops same-cycle rises; req_prev_q still tracks so held lines stay quiet.
        state_q    <= IDLE;
        pending    <= '0;
        onehot_out <= '0;
        valid_out  <= 1'b0;
        overflow   <= 1'b0;
      end else begin
        pending  <= pending_d;
        overflow <= overflow_d;
        case (state_q)
          IDLE: begin
            if (|pending) begin
              onehot_out <= sel_high(pending);
              valid_out  <= 1'b1;
              state_q    <= PRESENT;
            end
          end
          PRESENT: begin
            // Hold until accepted; new arrivals only set pending, never preempt.
            if (acc) begin
              if (|rem) begin
                onehot_out <= sel_high(rem);
              end else begin
                onehot_out <= '0;
                valid_out  <= 1'b0;
                state_q    <= IDLE;
              end
            end
          end
          default: begin
            state_q    <= IDLE;
            onehot_out <= '0;
            valid_out  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_req_onehot_arbiter.sv
// Directed bench: stimulus pushes expected grants into a queue, a negedge monitor
// pops one per accepted grant and also checks the output invariants every cycle.
module tb_req_onehot_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] req_in;
  logic       clr_all;
  logic       ready_in;
  logic [7:0] onehot_out;
  logic       valid_out;
  logic [7:0] pending;
  logic       overflow;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];

  req_onehot_arbiter #(.N(8), .EDGE_MODE(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_in     (req_in),
    .clr_all    (clr_all),
    .ready_in   (ready_in),
    .onehot_out (onehot_out),
    .valid_out  (valid_out),
    .pending    (pending),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: grant order via scoreboard, plus invariants each cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_out) begin
        chk("inv_onehot", 32'($countones(onehot_out)), 32'd1);
        chk("inv_subset", 32'(onehot_out & ~pending), 32'd0);
      end else begin
        chk("inv_idle_zero", 32'(onehot_out), 32'd0);
      end
      if (valid_out && ready_in) begin
        if (exp_q.size() == 0) begin
          chk("grant_unexpected", 32'(onehot_out), 32'd0);
        end else begin
          chk("grant", 32'(onehot_out), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    req_in   = '0;
    clr_all  = 1'b0;
    ready_in = 1'b1;
    tick();
    tick();
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_onehot", 32'(onehot_out), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;

    // Single request, 2-edge latency
    exp_q.push_back(8'h04);
    req_in = 8'h04;
    tick();
    req_in = '0;
    chk("single_pending", 32'(pending), 32'h04);
    chk("single_not_yet_valid", 32'(valid_out), 32'd0);
    tick();
    chk("single_valid", 32'(valid_out), 32'd1);
    chk("single_onehot", 32'(onehot_out), 32'h04);
    tick();
    chk("single_done_valid", 32'(valid_out), 32'd0);
    chk("single_done_onehot", 32'(onehot_out), 32'd0);
    chk("single_done_pending", 32'(pending), 32'd0);

    // Priority order, back-to-back grants
    exp_q.push_back(8'h80);
    exp_q.push_back(8'h40);
    exp_q.push_back(8'h01);
    req_in = 8'hC1;
    tick();
    req_in = '0;
    tick();
    chk("b2b_first", 32'(onehot_out), 32'h80);
    tick();
    tick();
    tick();
    chk("b2b_end_valid", 32'(valid_out), 32'd0);
    chk("b2b_end_pending", 32'(pending), 32'd0);

    // Backpressure, no preemption by a higher arrival
    ready_in = 1'b0;
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h80);
    req_in = 8'h02;
    tick();
    req_in = '0;
    tick();
    req_in = 8'h80;
    tick();
    req_in = '0;
    tick();
    chk("bp_hold_onehot", 32'(onehot_out), 32'h02);
    chk("bp_pending", 32'(pending), 32'h82);
    chk("bp_valid", 32'(valid_out), 32'd1);
    ready_in = 1'b1;
    tick();
    chk("bp_next_onehot", 32'(onehot_out), 32'h80);
    tick();
    chk("bp_end_valid", 32'(valid_out), 32'd0);

    // Overflow pulse, then set-wins-over-clear in the accept cycle
    ready_in = 1'b0;
    exp_q.push_back(8'h08);
    exp_q.push_back(8'h08);
    req_in = 8'h08;
    tick();
    req_in = '0;
    chk("ovf_first_rise", 32'(overflow), 32'd0);
    tick();
    req_in = 8'h08;
    tick();
    req_in = '0;
    chk("ovf_pulse", 32'(overflow), 32'd1);
    tick();
    chk("ovf_one_cycle", 32'(overflow), 32'd0);
    ready_in = 1'b1;
    req_in   = 8'h08;
    tick();
    req_in = '0;
    chk("setwins_pending", 32'(pending), 32'h08);
    chk("setwins_no_ovf", 32'(overflow), 32'd0);
    chk("setwins_idle", 32'(valid_out), 32'd0);
    tick();
    chk("setwins_represent", 32'(onehot_out), 32'h08);
    tick();
    chk("setwins_end_valid", 32'(valid_out), 32'd0);

    // clr_all mid-operation discards a simultaneous rise
    ready_in = 1'b0;
    req_in   = 8'h55;
    tick();
    req_in = '0;
    tick();
    chk("clr_pre_pending", 32'(pending), 32'h55);
    chk("clr_pre_onehot", 32'(onehot_out), 32'h40);
    clr_all = 1'b1;
    req_in  = 8'h80;
    tick();
    clr_all = 1'b0;
    req_in  = '0;
    chk("clr_pending", 32'(pending), 32'd0);
    chk("clr_valid", 32'(valid_out), 32'd0);
    chk("clr_onehot", 32'(onehot_out), 32'd0);
    tick();
    tick();
    chk("clr_no_grant_valid", 32'(valid_out), 32'd0);
    chk("clr_no_grant_pending", 32'(pending), 32'd0);

    // Async reset mid-transfer; held bit 0 counts as a rise after release
    req_in = 8'h10;
    tick();
    req_in = '0;
    tick();
    chk("arst_pre_valid", 32'(valid_out), 32'd1);
    #2;
    rst_n  = 1'b0;
    req_in = 8'h01;
    #1;
    chk("arst_valid", 32'(valid_out), 32'd0);
    chk("arst_onehot", 32'(onehot_out), 32'd0);
    chk("arst_pending", 32'(pending), 32'd0);
    chk("arst_overflow", 32'(overflow), 32'd0);
    #1;
    rst_n = 1'b1;
    tick();
    chk("arst_held_pending", 32'(pending), 32'h01);
    chk("arst_held_not_valid", 32'(valid_out), 32'd0);
    tick();
    chk("arst_held_onehot", 32'(onehot_out), 32'h01);
    exp_q.push_back(8'h01);
    ready_in = 1'b1;
    tick();
    req_in = '0;
    chk("arst_end_valid", 32'(valid_out), 32'd0);
    chk("arst_end_pending", 32'(pending), 32'd0);
    tick();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
